// File: rtl/seq_divider_if.sv
// seq_divider_if
//   Operand/result bundle for the sequential divider.
//   master : drives start/data_in, observes results (test harness / host)
//   slave  : the divider itself
//   start   - level request, only looked at while idle or done
//   data_in - operand bus: dividend then divisor on consecutive cycles
//   quot    - quotient, valid while done
//   rem     - remainder, valid while done
//   done    - result valid
//   busy    - loading or computing
//   dz      - divide-by-zero flag, valid while done
interface seq_divider_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic             done;
    logic             busy;
    logic             dz;

    modport master (
        output start, data_in,
        input  quot, rem, done, busy, dz
    );

    modport slave (
        input  start, data_in,
        output quot, rem, done, busy, dz
    );
endinterface

// File: rtl/seq_divider.sv
// seq_divider
//   Unsigned repeated-subtraction divider. After start is seen in IDLE the
//   dividend and divisor are taken from data_in on the next two edges, then
//   one subtraction is done per cycle until the remainder drops below the
//   divisor. Results are held in DONE until start is released.
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - seq_divider_if.slave (start, data_in, quot, rem, done, busy, dz)
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LDA  = 3'd1,
        S_LDB  = 3'd2,
        S_CALC = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_reg;   // dividend, becomes the remainder
    logic [WIDTH-1:0] b_reg;   // divisor
    logic [WIDTH-1:0] q_reg;   // quotient
    logic             dz_reg;
    logic             busy_o, done_o;

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (bus.start) state_nxt = S_LDA;
            S_LDA:  state_nxt = S_LDB;
            S_LDB:  state_nxt = S_CALC;
            S_CALC: begin
                // zero divisor exits immediately; otherwise stay while a >= b
                if (b_reg == '0)        state_nxt = S_DONE;
                else if (a_reg < b_reg) state_nxt = S_DONE;
            end
            S_DONE: if (!bus.start) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // output decode, registered state only
    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        case (state)
            S_LDA, S_LDB, S_CALC: busy_o = 1'b1;
            S_DONE:               done_o = 1'b1;
            default: ;
        endcase
    end

    // datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg  <= '0;
            b_reg  <= '0;
            q_reg  <= '0;
            dz_reg <= 1'b0;
        end else begin
            case (state)
                S_LDA: begin
                    a_reg  <= bus.data_in;
                    dz_reg <= 1'b0;
                end
                S_LDB: begin
                    b_reg <= bus.data_in;
                    q_reg <= '0;
                end
                S_CALC: begin
                    if (b_reg == '0) begin
                        dz_reg <= 1'b1;
                    end else if (a_reg >= b_reg) begin
                        // guarded by a >= b, so no underflow; q <= dividend, so no overflow
                        a_reg <= a_reg - b_reg;
                        q_reg <= q_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.quot = q_reg;
    assign bus.rem  = a_reg;
    assign bus.dz   = dz_reg;
    assign bus.busy = busy_o;
    assign bus.done = done_o;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider
//   Directed-vector bench for seq_divider. Stimulus pushes hand-computed
//   results (quotient, remainder, dz, start-to-done latency) into a queue;
//   a negedge monitor pops one entry per rising done and compares.
module tb_seq_divider;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           k;
        int           lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   overlap = 0;
    logic done_q = 1'b0;
    exp_t sb[$];

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (bus.done && !done_q) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("quot", 32'(bus.quot), 32'(e.q));
                chk("rem",  32'(bus.rem),  32'(e.r));
                chk("dz",   32'(bus.dz),   32'(e.dz));
                chk("latency", 32'(cyc - e.k), 32'(e.lat));
            end
        end
        if (bus.busy && bus.done) overlap++;
        done_q = bus.done;
    end

    // issue start (sampled at the next edge = k), then dividend, then divisor
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] q, input logic [W-1:0] r,
                            input logic dz, input bit keep);
        exp_t e;
        e.q = q; e.r = r; e.dz = dz;
        e.k = cyc + 1;
        e.lat = 3 + int'(q);
        if (rst == 1'b0) sb.push_back(e);
        bus.start = 1'b1;
        @(negedge clk);
        bus.data_in = a;
        if (!keep) bus.start = 1'b0;
        @(negedge clk);
        bus.data_in = b;
    endtask

    // wait for done with a cycle budget; optionally require busy until then
    task automatic wait_done(input string name, input bit chk_busy, input bit toggle);
        int n = 0;
        int busy_gap = 0;
        while (!bus.done && n < 70000) begin
            @(negedge clk);
            n++;
            if (!bus.done && !bus.busy) busy_gap++;
            if (toggle) bus.data_in = W'($urandom);
        end
        if (!bus.done) chk({name, "_timeout"}, 32'd0, 32'd1);
        if (chk_busy) chk({name, "_busy_gaps"}, 32'(busy_gap), 32'd0);
    endtask

    task automatic end_op();
        bus.start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bit stable_bad;
        bus.start   = 1'b0;
        bus.data_in = '0;
        rst         = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_quot", 32'(bus.quot), 32'd0);
        chk("rst_rem",  32'(bus.rem),  32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_dz",   32'(bus.dz),   32'd0);
        rst = 1'b0;
        @(negedge clk);

        start_op(16'd7, 16'd2, 16'd3, 16'd1, 1'b0, 1'b0); wait_done("d7_2", 1'b1, 1'b0); end_op();
        start_op(16'd2, 16'd3, 16'd0, 16'd2, 1'b0, 1'b0); wait_done("d2_3", 1'b1, 1'b0); end_op();
        start_op(16'd5, 16'd5, 16'd1, 16'd0, 1'b0, 1'b0); wait_done("d5_5", 1'b1, 1'b0); end_op();
        start_op(16'd0, 16'd9, 16'd0, 16'd0, 1'b0, 1'b0); wait_done("d0_9", 1'b1, 1'b0); end_op();
        start_op(16'd5, 16'd0, 16'd0, 16'd5, 1'b1, 1'b0); wait_done("d5_0", 1'b1, 1'b0); end_op();
        start_op(16'd9, 16'd4, 16'd2, 16'd1, 1'b0, 1'b0); wait_done("d9_4", 1'b1, 1'b0); end_op();
        start_op(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 1'b0); wait_done("dffff_1", 1'b1, 1'b0); end_op();

        // 100/3 interrupted by reset at edge k+10, start held throughout
        begin
            int k0;
            k0 = cyc + 1;
            bus.start = 1'b1;
            @(negedge clk); bus.data_in = 16'd100;
            @(negedge clk); bus.data_in = 16'd3;
            while (cyc < k0 + 9) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            chk("midrst_quot", 32'(bus.quot), 32'd0);
            chk("midrst_rem",  32'(bus.rem),  32'd0);
            chk("midrst_done", 32'(bus.done), 32'd0);
            chk("midrst_busy", 32'(bus.busy), 32'd0);
            chk("midrst_dz",   32'(bus.dz),   32'd0);
            rst = 1'b0;
            start_op(16'd100, 16'd3, 16'd33, 16'd1, 1'b0, 1'b1);
            @(negedge clk);
            chk("post_rst_busy", 32'(bus.busy), 32'd1);
            wait_done("d100_3", 1'b1, 1'b0);
        end

        // start held through done: results must stay put
        stable_bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus.done || bus.quot !== 16'd33 || bus.rem !== 16'd1) stable_bad = 1'b1;
        end
        chk("hold_stable", 32'(stable_bad), 32'd0);
        end_op();
        chk("idle_done", 32'(bus.done), 32'd0);
        chk("idle_busy", 32'(bus.busy), 32'd0);

        start_op(16'd20, 16'd6, 16'd3, 16'd2, 1'b0, 1'b1); wait_done("d20_6", 1'b1, 1'b0); end_op();

        // data_in noise during CALC
        start_op(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0); wait_done("d100_7", 1'b1, 1'b1); end_op();

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("busy_done_overlap", 32'(overlap), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
